sram_2_16_march_bist: RTL and testbench

- Built-in self-test sequencer directly upstream of the sram_2_16_scn4m_subm macro.
- It drives the macro's command port (csb0, web0, addr0, din0) and consumes dout0.
- It runs a 4-element March C-style sequence over all 16 words and reports pass/fail, the first failing address and a mismatch count.
- It replaces hand-written write-then-readback benches for silicon and post-layout checks.

---
 rtl/sram_2_16_march_bist_if.sv | 14 +
 rtl/sram_2_16_march_bist.sv | 182 ++++++++++++++++++
 tb/tb_sram_2_16_march_bist.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_2_16_march_bist_if.sv
// rtl/sram_2_16_march_bist_if.sv - command/read-data port of the sram_2_16 macro
interface sram_2_16_march_bist_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 2
);
  logic                  csb0;
  logic                  web0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;

  modport master (output csb0, output web0, output addr0, output din0, input dout0);
  modport slave  (input csb0, input web0, input addr0, input din0, output dout0);
endinterface

// File: rtl/sram_2_16_march_bist.sv
// rtl/sram_2_16_march_bist.sv - March C-style BIST sequencer for the sram_2_16 macro
module sram_2_16_march_bist #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0] DATA_BG    = DATA_WIDTH'(2'b01),
  parameter int                    READ_LAT   = 1,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  start,
  sram_2_16_march_bist_if.master sram,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  typedef enum logic [2:0] {IDLE, W0_UP, RW_UP, WR_DN, R0_DN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  wr_n, accept;
  logic                  csb_n, web_n;
  logic [DATA_WIDTH-1:0] din_n, exp_n, exp_q;
  logic                  busy_n, done_n;

  logic [READ_LAT-1:0]   pipe_v;
  logic [DATA_WIDTH-1:0] pipe_e [READ_LAT];
  logic [ADDR_WIDTH-1:0] pipe_a [READ_LAT];
  logic                  rd_now, mism;

  // The currently driven command doubles as the sequencer position: addr0 is
  // the address counter and web0 tells the read half from the write half.
  always_comb begin
    state_n = state;
    addr_n  = '0;
    wr_n    = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = W0_UP;
          accept  = 1'b1;
        end
      end
      W0_UP: begin
        if (sram.addr0 == ADDR_MAX) state_n = RW_UP;
        else                        addr_n  = sram.addr0 + ADDR_ONE;
      end
      RW_UP: begin
        if (sram.web0) begin
          wr_n   = 1'b1;
          addr_n = sram.addr0;
        end else if (sram.addr0 == ADDR_MAX) begin
          state_n = WR_DN;
          addr_n  = ADDR_MAX;
        end else begin
          addr_n = sram.addr0 + ADDR_ONE;
        end
      end
      WR_DN: begin
        if (sram.web0) begin
          wr_n   = 1'b1;
          addr_n = sram.addr0;
        end else if (sram.addr0 == '0) begin
          state_n = R0_DN;
          addr_n  = ADDR_MAX;
        end else begin
          addr_n = sram.addr0 - ADDR_ONE;
        end
      end
      R0_DN: begin
        if (sram.addr0 == '0) state_n = DRAIN;
        else                  addr_n  = sram.addr0 - ADDR_ONE;
      end
      DRAIN: begin
        if (pipe_v == '0) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    csb_n = 1'b1;
    web_n = 1'b1;
    din_n = '0;
    exp_n = '0;
    case (state_n)
      W0_UP: begin
        csb_n = 1'b0;
        web_n = 1'b0;
        din_n = DATA_BG;
      end
      RW_UP: begin
        csb_n = 1'b0;
        exp_n = DATA_BG;
        if (wr_n) begin
          web_n = 1'b0;
          din_n = ~DATA_BG;
        end
      end
      WR_DN: begin
        csb_n = 1'b0;
        exp_n = ~DATA_BG;
        if (wr_n) begin
          web_n = 1'b0;
          din_n = DATA_BG;
        end
      end
      R0_DN: begin
        csb_n = 1'b0;
        exp_n = DATA_BG;
      end
      default: ;
    endcase
    busy_n = (state_n != IDLE) && (state_n != DONE);
    done_n = (state_n == DONE);
  end

  // 4-state inequality so an X/Z read-back is scored as a mismatch.
  assign rd_now = ~sram.csb0 & sram.web0;
  assign mism   = pipe_v[READ_LAT-1] && (sram.dout0 !== pipe_e[READ_LAT-1]);

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sram.csb0  <= 1'b1;
      sram.web0  <= 1'b1;
      sram.addr0 <= '0;
      sram.din0  <= '0;
      exp_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
      pipe_v     <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_e[i] <= '0;
        pipe_a[i] <= '0;
      end
    end else begin
      state      <= state_n;
      sram.csb0  <= csb_n;
      sram.web0  <= web_n;
      sram.addr0 <= addr_n;
      sram.din0  <= din_n;
      exp_q      <= exp_n;
      busy       <= busy_n;
      done       <= done_n;

      pipe_v[0] <= rd_now;
      pipe_e[0] <= exp_q;
      pipe_a[0] <= sram.addr0;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end

      if (accept) begin
        fail       <= 1'b0;
        fail_addr  <= '0;
        fail_count <= '0;
      end else if (mism) begin
        if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_ONE;
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= pipe_a[READ_LAT-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_2_16_march_bist.sv
// tb/tb_sram_2_16_march_bist.sv - directed bench for the March BIST with faulty SRAM models
module tb_sram_2_16_march_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0;
  always #5 clk = ~clk;

  sram_2_16_march_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(2)) b1 ();
  sram_2_16_march_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(2)) b2 ();

  logic       busy1, done1, fail1, busy2, done2, fail2;
  logic [3:0] faddr1, faddr2;
  logic [7:0] cnt1, cnt2;

  sram_2_16_march_bist #(.READ_LAT(1)) dut1 (
    .clk0(clk), .rst(rst), .start(start1), .sram(b1),
    .busy(busy1), .done(done1), .fail(fail1), .fail_addr(faddr1), .fail_count(cnt1));
  sram_2_16_march_bist #(.READ_LAT(2)) dut2 (
    .clk0(clk), .rst(rst), .start(start2), .sram(b2),
    .busy(busy2), .done(done2), .fail(fail2), .fail_addr(faddr2), .fail_count(cnt2));

  // Behavioural macros; faults are applied to the read path only.
  int fkind = 0;
  int fword = 0;
  logic [1:0] mem1 [16];
  logic [1:0] mem2 [16];
  logic [1:0] r1, r2a, r2b;

  function automatic logic [1:0] rd_fault(input logic [3:0] a, input logic [1:0] d);
    if (int'(a) != fword) return d;
    case (fkind)
      1: return d | 2'b01;
      2: return d & 2'b10;
      3: return 2'bxx;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!b1.csb0) begin
      if (!b1.web0) mem1[b1.addr0] <= b1.din0;
      else          r1 <= rd_fault(b1.addr0, mem1[b1.addr0]);
    end
    if (!b2.csb0) begin
      if (!b2.web0) mem2[b2.addr0] <= b2.din0;
      else          r2a <= rd_fault(b2.addr0, mem2[b2.addr0]);
    end
    r2b <= r2a;
  end
  assign b1.dout0 = r1;
  assign b2.dout0 = r2b;

  int sel = 0;
  logic       m_csb, m_web, m_busy, m_done, m_fail;
  logic [3:0] m_addr, m_faddr;
  logic [7:0] m_cnt;
  assign m_csb   = sel ? b2.csb0  : b1.csb0;
  assign m_web   = sel ? b2.web0  : b1.web0;
  assign m_addr  = sel ? b2.addr0 : b1.addr0;
  assign m_busy  = sel ? busy2    : busy1;
  assign m_done  = sel ? done2    : done1;
  assign m_fail  = sel ? fail2    : fail1;
  assign m_faddr = sel ? faddr2   : faddr1;
  assign m_cnt   = sel ? cnt2     : cnt1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [3:0] exp_addr(input int c);
    if (c <= 16) return 4'(c - 1);
    if (c <= 48) return 4'((c - 17) / 2);
    if (c <= 80) return 4'(15 - (c - 49) / 2);
    return 4'(15 - (c - 81));
  endfunction

  function automatic logic exp_web(input int c);
    if (c <= 16) return 1'b0;
    if (c <= 80) return ((c - 17) % 2 == 1) ? 1'b0 : 1'b1;
    return 1'b1;
  endfunction

  // Pulses (or holds) start, then follows the run edge by edge until done.
  task automatic run_vec(input bit hold, output int done_edge, output int seq_err, output int wlow);
    done_edge = -1;
    seq_err   = 0;
    wlow      = 0;
    @(negedge clk);
    if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!hold) begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
      if (m_done === 1'b1) begin
        done_edge = k;
        break;
      end
      if (k + 1 <= 96) begin
        if (m_csb !== 1'b0 || m_addr !== exp_addr(k + 1) || m_web !== exp_web(k + 1)) seq_err++;
        if (m_web === 1'b0) wlow++;
      end else if (m_csb !== 1'b1) begin
        seq_err++;
      end
    end
  endtask

  typedef struct {
    int   sel;
    int   fkind;
    int   fword;
    logic fail;
    int   faddr;
    int   cnt;
    int   done_edge;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int de, se, wl;
    vecs[0] = '{0, 0, 0, 1'b0, 0, 0, 98};
    vecs[1] = '{0, 1, 9, 1'b1, 9, 1, 98};
    vecs[2] = '{0, 2, 3, 1'b1, 3, 2, 98};
    vecs[3] = '{0, 3, 6, 1'b1, 6, 3, 98};
    vecs[4] = '{1, 0, 0, 1'b0, 0, 0, 99};
    vecs[5] = '{1, 2, 3, 1'b1, 3, 2, 99};

    repeat (3) @(negedge clk);
    check("rst csb0", b1.csb0, 1);
    check("rst web0", b1.web0, 1);
    check("rst addr0", b1.addr0, 0);
    check("rst din0", b1.din0, 0);
    check("rst busy/done/fail", {busy1, done1, fail1}, 0);
    check("rst fail_addr/count", {faddr1, cnt1}, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      sel   = vecs[v].sel;
      fkind = vecs[v].fkind;
      fword = vecs[v].fword;
      run_vec(1'b0, de, se, wl);
      check($sformatf("v%0d done edge", v), de, vecs[v].done_edge);
      check($sformatf("v%0d cmd sequence errors", v), se, 0);
      check($sformatf("v%0d web0 low cycles", v), wl, 48);
      check($sformatf("v%0d busy after done", v), m_busy, 0);
      check($sformatf("v%0d fail", v), m_fail, vecs[v].fail);
      check($sformatf("v%0d fail_addr", v), m_faddr, vecs[v].faddr);
      check($sformatf("v%0d fail_count", v), m_cnt, vecs[v].cnt);
    end

    // Asynchronous reset in the middle of a failing run.
    sel   = 0;
    fkind = 2;
    fword = 3;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (39) @(negedge clk);
    check("mid-run fail before rst", fail1, 1);
    check("mid-run busy before rst", busy1, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst csb0", b1.csb0, 1);
    check("async rst busy", busy1, 0);
    check("async rst done", done1, 0);
    check("async rst fail", fail1, 0);
    check("async rst fail_count", cnt1, 0);
    check("async rst addr0", b1.addr0, 0);
    @(negedge clk); rst = 1'b0;
    fkind = 0;
    run_vec(1'b0, de, se, wl);
    check("post-rst done edge", de, 98);
    check("post-rst cmd sequence errors", se, 0);
    check("post-rst fail", fail1, 0);

    // start held high: ignored while busy, restarts immediately from DONE.
    fkind = 1;
    fword = 9;
    run_vec(1'b1, de, se, wl);
    check("held done edge", de, 98);
    check("held cmd sequence errors", se, 0);
    check("held fail", fail1, 1);
    check("held fail_count", cnt1, 1);
    @(negedge clk);
    check("restart done", done1, 0);
    check("restart busy", busy1, 1);
    check("restart fail", fail1, 0);
    check("restart fail_count", cnt1, 0);
    check("restart first cmd", {b1.csb0, b1.web0, b1.addr0}, 0);
    start1 = 1'b0;
    de = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        de = k;
        break;
      end
    end
    check("restart run completes", de >= 0, 1);
    check("restart run fail_count", cnt1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
